// File: rtl/prio_enc_4to2.sv
// rtl/prio_enc_4to2.sv - 4-to-2 MSB-first priority encoder with registered index and valid
module prio_enc_4to2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d,
   output logic [1:0] q,
   output logic       v
);

   logic [1:0] q_next;
   logic       v_next;

   // Strict MSB-first decode; idle input yields index 0 with valid low
   always_comb begin
      q_next = 2'd0;
      v_next = |d;
      casez (d)
         4'b1???: q_next = 2'd3;
         4'b01??: q_next = 2'd2;
         4'b001?: q_next = 2'd1;
         default: q_next = 2'd0;
      endcase
   end

   // Output register; reset clears immediately so a pending sample is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= 2'd0;
         v <= 1'b0;
      end else begin
         q <= q_next;
         v <= v_next;
      end
   end

endmodule

// File: tb/tb_prio_enc_4to2.sv
// tb/tb_prio_enc_4to2.sv - directed and exhaustive bench for prio_enc_4to2
`timescale 1ns/1ps
module tb_prio_enc_4to2;

   logic       clk;
   logic       reset_n;
   logic [3:0] d;
   logic [1:0] q;
   logic       v;

   int errors;
   int checks;

   prio_enc_4to2 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (d),
      .q       (q),
      .v       (v)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Independent reference: scan upward, last set bit wins
   function automatic logic [1:0] ref_idx(input logic [3:0] val);
      logic [1:0] r;
      r = 2'd0;
      for (int b = 0; b < 4; b++)
         if (val[b]) r = b[1:0];
      return r;
   endfunction

   // Drive d on the falling edge, then settle just past the next rising edge
   task automatic step(input logic [3:0] val);
      @(negedge clk);
      d = val;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_qv(input string name, input logic [1:0] eq, input logic ev);
      checks++;
      if (q !== eq || v !== ev) begin
         errors++;
         $display("FAIL %s: got q=%0d v=%0b, expected q=%0d v=%0b", name, q, v, eq, ev);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      d = 4'b1111;
      #1;
      checks++;
      if (q !== 2'd0 || v !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: got q=%0d v=%0b, expected q=0 v=0", q, v);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (q !== 2'd0 || v !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cycle %0d got q=%0d v=%0b, expected q=0 v=0", i, q, v);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (q !== 2'd3 || v !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got q=%0d v=%0b, expected q=3 v=1", q, v);
      end
      // Asynchronous assertion mid-cycle, no clock edge involved
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (q !== 2'd0 || v !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got q=%0d v=%0b, expected q=0 v=0", q, v);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_one_hot();
      step(4'b0001); expect_qv("onehot_0001", 2'd0, 1'b1);
      step(4'b0010); expect_qv("onehot_0010", 2'd1, 1'b1);
      step(4'b0100); expect_qv("onehot_0100", 2'd2, 1'b1);
      step(4'b1000); expect_qv("onehot_1000", 2'd3, 1'b1);
   endtask

   task automatic test_zero();
      step(4'b0000); expect_qv("zero_idle", 2'd0, 1'b0);
      step(4'b0001); expect_qv("zero_then_bit0", 2'd0, 1'b1);
   endtask

   task automatic test_priority();
      step(4'b1111); expect_qv("prio_1111", 2'd3, 1'b1);
      step(4'b1001); expect_qv("prio_1001", 2'd3, 1'b1);
      step(4'b0101); expect_qv("prio_0101", 2'd2, 1'b1);
      step(4'b0011); expect_qv("prio_0011", 2'd1, 1'b1);
      step(4'b0110); expect_qv("prio_0110", 2'd2, 1'b1);
   endtask

   task automatic test_exhaustive();
      logic [3:0] prev;
      logic [1:0] eq;
      logic       ev;
      prev = 4'b0000;
      step(prev);
      for (int i = 0; i < 16; i++) begin
         // Before the sampling edge the outputs still reflect the previous value
         @(negedge clk);
         checks++;
         eq = ref_idx(prev);
         ev = (prev != 4'b0000);
         if (q !== eq || v !== ev) begin
            errors++;
            $display("FAIL exh_hold d=%b: got q=%0d v=%0b, expected q=%0d v=%0b", prev, q, v, eq, ev);
         end
         d = i[3:0];
         @(posedge clk);
         #1;
         checks++;
         eq = ref_idx(i[3:0]);
         ev = (i != 0);
         if (q !== eq || v !== ev) begin
            errors++;
            $display("FAIL exh d=%b: got q=%0d v=%0b, expected q=%0d v=%0b", i[3:0], q, v, eq, ev);
         end
         prev = i[3:0];
      end
   endtask

   task automatic test_latency();
      step(4'b0010);
      expect_qv("lat_base", 2'd1, 1'b1);
      // Change d well before the next edge; outputs must not follow it
      #1;
      d = 4'b1000;
      #2;
      expect_qv("lat_no_comb_path", 2'd1, 1'b1);
      d = 4'b0000;
      #1;
      expect_qv("lat_no_comb_path2", 2'd1, 1'b1);
      @(posedge clk);
      #1;
      expect_qv("lat_after_edge", 2'd0, 1'b0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      reset_n = 1'b0;
      d       = 4'b0000;
      test_reset();
      test_one_hot();
      test_zero();
      test_priority();
      test_exhaustive();
      test_latency();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
